// File: rtl/cplx_sram_streamer.sv
// Streams one frame of complex samples into external dual-port SRAM, then
// reads the frame back out in order through a 2-entry output buffer.
module cplx_sram_streamer #(
  parameter int unsigned DEPTH = 480,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_real,
  input  logic [31:0]   in_imag,
  output logic          full,
  input  logic          unload_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_real,
  output logic [31:0]   out_imag,
  output logic          unload_done,
  output logic [3:0]    sram_wea0,
  output logic [AW-1:0] sram_addr0,
  output logic [31:0]   re_wdata0,
  output logic [31:0]   im_wdata0,
  output logic [AW-1:0] sram_addr1,
  input  logic [31:0]   re_rdata1,
  input  logic [31:0]   im_rdata1
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, UNLOAD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wr_cnt, rd_cnt, out_cnt;
  logic [31:0]   buf_re [2];
  logic [31:0]   buf_im [2];
  logic          rptr, wptr;
  logic [1:0]    count;
  logic          inflight;
  logic [2:0]    occ;
  logic          in_fire, out_fire, rd_active, rd_issue, last_in, last_out;

  assign in_fire  = in_valid && (state == LOAD);
  assign out_fire = out_ready && (count != 2'd0);
  assign last_in  = in_fire && (wr_cnt == CW'(DEPTH - 1));
  assign last_out = out_fire && (out_cnt == CW'(DEPTH - 1));

  // The first read is issued in the FULL cycle that accepts unload_start so
  // that data reaches the output two cycles after the start request.
  assign rd_active = (state == UNLOAD) || ((state == FULL) && unload_start);
  assign occ       = 3'(count) + 3'(inflight) - 3'(out_fire);
  assign rd_issue  = rd_active && (rd_cnt < CW'(DEPTH)) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_start)   state_nxt = LOAD;
      LOAD:    if (last_in)      state_nxt = FULL;
      FULL:    if (unload_start) state_nxt = UNLOAD;
      UNLOAD:  if (last_out)     state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == LOAD);
    full       = (state == FULL);
    out_valid  = (count != 2'd0);
    sram_wea0  = in_fire ? 4'hF : 4'h0;
    sram_addr0 = in_fire ? AW'(wr_cnt) : '0;
    re_wdata0  = in_fire ? in_real : '0;
    im_wdata0  = in_fire ? in_imag : '0;
    sram_addr1 = rd_issue ? AW'(rd_cnt) : '0;
    out_real   = out_valid ? buf_re[rptr] : '0;
    out_imag   = out_valid ? buf_im[rptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      out_cnt     <= '0;
      inflight    <= 1'b0;
      count       <= '0;
      rptr        <= 1'b0;
      wptr        <= 1'b0;
      unload_done <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      if ((state == IDLE) && load_start) begin
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_fire)  wr_cnt  <= wr_cnt + CW'(1);
        if (rd_issue) rd_cnt  <= rd_cnt + CW'(1);
        if (out_fire) out_cnt <= out_cnt + CW'(1);
      end
      inflight <= rd_issue;
      if (inflight) begin
        buf_re[wptr] <= re_rdata1;
        buf_im[wptr] <= im_rdata1;
        wptr         <= ~wptr;
      end
      if (out_fire) rptr <= ~rptr;
      count       <= count + 2'(inflight) - 2'(out_fire);
      unload_done <= last_out;
    end
  end

endmodule

// File: tb/tb_cplx_sram_streamer.sv
// Directed bench for cplx_sram_streamer with a behavioural dual-port SRAM.
module tb_cplx_sram_streamer;

  logic        clk = 1'b0;
  logic        rst, load_start, in_valid, unload_start, out_ready;
  logic [31:0] in_real, in_imag;
  logic        in_ready, full, out_valid, unload_done;
  logic [31:0] out_real, out_imag;
  logic [3:0]  sram_wea0;
  logic [15:0] sram_addr0, sram_addr1;
  logic [31:0] re_wdata0, im_wdata0, re_rdata1, im_rdata1;

  logic [31:0] mre [0:1023];
  logic [31:0] mim [0:1023];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cplx_sram_streamer #(.DEPTH(480), .AW(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .full(full),
    .unload_start(unload_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .unload_done(unload_done),
    .sram_wea0(sram_wea0), .sram_addr0(sram_addr0),
    .re_wdata0(re_wdata0), .im_wdata0(im_wdata0),
    .sram_addr1(sram_addr1), .re_rdata1(re_rdata1), .im_rdata1(im_rdata1)
  );

  always @(posedge clk) begin
    if (sram_wea0 == 4'hF) begin
      mre[sram_addr0[9:0]] <= re_wdata0;
      mim[sram_addr0[9:0]] <= im_wdata0;
    end
    re_rdata1 <= mre[sram_addr1[9:0]];
    im_rdata1 <= mim[sram_addr1[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, c, idx;
    logic started, prev_stall;
    logic [31:0] held_re, held_im;

    rst = 1'b1; load_start = 1'b0; unload_start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_real = '0; in_imag = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_unload_done", 32'(unload_done), 32'd0);
    chk("rst_wea0", 32'(sram_wea0), 32'h0);
    chk("rst_addr0", 32'(sram_addr0), 32'd0);
    chk("rst_addr1", 32'(sram_addr1), 32'd0);
    chk("rst_out_real", out_real, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // unload_start and in_valid while IDLE do nothing
    unload_start = 1'b1; in_valid = 1'b1; in_real = 32'hDEAD;
    #1;
    chk("idle_wea0", 32'(sram_wea0), 32'h0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_addr1", 32'(sram_addr1), 32'd0);
    @(negedge clk);
    unload_start = 1'b0; in_valid = 1'b0;
    #1;
    chk("idle_full", 32'(full), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Frame A: gappy in_valid, reset after 200 transfers
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    #1 chk("loadA_in_ready", 32'(in_ready), 32'd1);
    n = 0; c = 0;
    while (n < 200 && c < 2000) begin
      in_valid = ((c % 3) != 1);
      in_real = 32'(n + 1000); in_imag = 32'(n);
      #1;
      chk("togg_wea0", 32'(sram_wea0), in_valid ? 32'hF : 32'h0);
      if (in_valid) chk("togg_addr0", 32'(sram_addr0), 32'(n));
      @(negedge clk);
      if (in_valid) n++;
      c++;
    end
    in_valid = 1'b0;
    chk("togg_count", 32'(n), 32'd200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_full", 32'(full), 32'd0);

    // Frame B: simultaneous starts in IDLE, load wins
    @(negedge clk);
    load_start = 1'b1; unload_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; unload_start = 1'b0;
    #1 chk("loadB_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 480; k++) begin
      in_valid = 1'b1; in_real = 32'(k); in_imag = ~k;
      #1;
      chk("loadB_wea0", 32'(sram_wea0), 32'hF);
      chk("loadB_addr0", 32'(sram_addr0), 32'(k));
      chk("loadB_re", re_wdata0, 32'(k));
      chk("loadB_im", im_wdata0, ~k);
      chk("loadB_full", 32'(full), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("B_full", 32'(full), 32'd1);
    chk("B_in_ready", 32'(in_ready), 32'd0);

    // load_start and in_valid in FULL are ignored
    @(negedge clk);
    load_start = 1'b1; in_valid = 1'b1;
    #1;
    chk("full_ld_wea0", 32'(sram_wea0), 32'h0);
    chk("full_ld_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b0;
    #1;
    chk("full_ld_full", 32'(full), 32'd1);
    chk("full_ld_out_valid", 32'(out_valid), 32'd0);

    // Unload B with out_ready high
    @(negedge clk);
    out_ready = 1'b1; unload_start = 1'b1;
    @(negedge clk);
    unload_start = 1'b0;
    #1;
    chk("unl_lat1_valid", 32'(out_valid), 32'd0);
    chk("unl_full", 32'(full), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 480; k++) begin
      #1;
      chk("unl_valid", 32'(out_valid), 32'd1);
      chk("unl_re", out_real, 32'(k));
      chk("unl_im", out_imag, ~k);
      chk("unl_done_early", 32'(unload_done), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("unl_done", 32'(unload_done), 32'd1);
    chk("unl_valid_end", 32'(out_valid), 32'd0);
    chk("unl_full_end", 32'(full), 32'd0);
    @(negedge clk);
    #1 chk("unl_done_pulse", 32'(unload_done), 32'd0);

    // Frame C then unload with stalls
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 480; k++) begin
      in_valid = 1'b1; in_real = 32'(k * 3); in_imag = 32'(k) ^ 32'h5A5A0000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 chk("C_full", 32'(full), 32'd1);
    @(negedge clk);
    unload_start = 1'b1;
    @(negedge clk);
    unload_start = 1'b0;
    idx = 0; c = 0; started = 1'b0; prev_stall = 1'b0;
    held_re = '0; held_im = '0;
    while (idx < 480 && c < 5000) begin
      out_ready = (((c * 13) % 7) < 4);
      #1;
      if (prev_stall) begin
        chk("stall_re_held", out_real, held_re);
        chk("stall_im_held", out_imag, held_im);
      end
      if (started) chk("no_gap", 32'(out_valid), 32'd1);
      if (out_valid) begin
        started = 1'b1;
        chk("stall_re", out_real, 32'(idx * 3));
        chk("stall_im", out_imag, 32'(idx) ^ 32'h5A5A0000);
      end
      prev_stall = out_valid && !out_ready;
      held_re = out_real; held_im = out_imag;
      if (out_valid && out_ready) idx++;
      @(negedge clk);
      c++;
    end
    chk("stall_count", 32'(idx), 32'd480);
    #1;
    chk("stall_done", 32'(unload_done), 32'd1);
    chk("stall_valid_end", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
